// File: rtl/btn_seq_ctrl.sv
// Two-button bit-entry controller: synchronise and debounce btnU/btnD, shift accepted bits
// into a history register, flag pattern matches and drive the LED bank.
module btn_seq_ctrl #(
    parameter int unsigned DEBOUNCE_CYC   = 1000,
    parameter int unsigned PATTERN_LEN    = 6,
    parameter logic [PATTERN_LEN-1:0] PATTERN = PATTERN_LEN'(6'b100110),
    parameter int unsigned TIMEOUT_CYC    = 5_000_000,
    parameter int unsigned MATCH_HOLD_CYC = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btnU,
    input  logic        btnD,
    output logic        bit_valid,
    output logic        bit_val,
    output logic        match,
    output logic [7:0]  match_cnt,
    output logic [15:0] led
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TO_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned HOLD_W = (MATCH_HOLD_CYC > 0) ? $clog2(MATCH_HOLD_CYC + 1) : 1;
    localparam int unsigned BC_W   = 4;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACCEPT, S_HELD} state_e;

    logic                   u_meta_q, u_sync_q, d_meta_q, d_sync_q;
    state_e                 state_q, state_d;
    logic                   rec_q, rec_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [PATTERN_LEN-1:0] hist_q, hist_d;
    logic [BC_W-1:0]        bcnt_q, bcnt_d;
    logic                   conflict_q, conflict_d;
    logic [TO_W-1:0]        idle_q, idle_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   hold_lit_q;
    logic                   bit_valid_q, bit_valid_d;
    logic                   bit_val_q, bit_val_d;
    logic                   match_q, match_d;
    logic [7:0]             match_cnt_q, match_cnt_d;

    logic                   rec_hi, oth_hi;
    logic [PATTERN_LEN-1:0] hist_shift;
    logic [BC_W-1:0]        bcnt_inc;

    assign rec_hi     = rec_q ? u_sync_q : d_sync_q;
    assign oth_hi     = rec_q ? d_sync_q : u_sync_q;
    assign hist_shift = {hist_q[PATTERN_LEN-2:0], rec_q};
    assign bcnt_inc   = (bcnt_q == BC_W'(PATTERN_LEN)) ? bcnt_q : bcnt_q + BC_W'(1);

    // Next-state and datapath; rec_q = 1 means btnU is the armed button.
    always_comb begin
        state_d     = state_q;
        rec_d       = rec_q;
        db_cnt_d    = db_cnt_q;
        hist_d      = hist_q;
        bcnt_d      = bcnt_q;
        conflict_d  = conflict_q;
        idle_d      = idle_q;
        match_d     = 1'b0;
        match_cnt_d = match_cnt_q;
        hold_d      = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;

        case (state_q)
            S_IDLE: begin
                if ((TIMEOUT_CYC != 0) && (idle_q != TO_W'(TIMEOUT_CYC))) begin
                    idle_d = idle_q + TO_W'(1);
                    if (idle_q == TO_W'(TIMEOUT_CYC - 1)) begin
                        hist_d = '0;
                        bcnt_d = '0;
                    end
                end
                if (u_sync_q && d_sync_q) begin
                    conflict_d = 1'b1;
                end else if (u_sync_q ^ d_sync_q) begin
                    state_d  = S_ARM;
                    rec_d    = u_sync_q;
                    db_cnt_d = '0;
                end
            end
            S_ARM: begin
                if (oth_hi) begin
                    state_d    = S_IDLE;
                    conflict_d = 1'b1;
                end else if (!rec_hi) begin
                    state_d = S_IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                    // The IDLE cycle that armed us counts as the first stable cycle.
                    if (db_cnt_q >= DB_W'(DEBOUNCE_CYC - 2)) begin
                        state_d = S_ACCEPT;
                    end
                end
            end
            S_ACCEPT: begin
                hist_d     = hist_shift;
                bcnt_d     = bcnt_inc;
                conflict_d = 1'b0;
                idle_d     = '0;
                db_cnt_d   = '0;
                state_d    = S_HELD;
                if ((bcnt_inc == BC_W'(PATTERN_LEN)) && (hist_shift == PATTERN)) begin
                    match_d     = 1'b1;
                    match_cnt_d = match_cnt_q + 8'd1;
                    hold_d      = HOLD_W'(MATCH_HOLD_CYC);
                end
            end
            S_HELD: begin
                if (u_sync_q || d_sync_q) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        bit_valid_d = (state_d == S_ACCEPT);
        bit_val_d   = rec_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_meta_q    <= 1'b0;
            u_sync_q    <= 1'b0;
            d_meta_q    <= 1'b0;
            d_sync_q    <= 1'b0;
            state_q     <= S_IDLE;
            rec_q       <= 1'b0;
            db_cnt_q    <= '0;
            hist_q      <= '0;
            bcnt_q      <= '0;
            conflict_q  <= 1'b0;
            idle_q      <= '0;
            hold_q      <= '0;
            hold_lit_q  <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_val_q   <= 1'b0;
            match_q     <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            u_meta_q    <= btnU;
            u_sync_q    <= u_meta_q;
            d_meta_q    <= btnD;
            d_sync_q    <= d_meta_q;
            state_q     <= state_d;
            rec_q       <= rec_d;
            db_cnt_q    <= db_cnt_d;
            hist_q      <= hist_d;
            bcnt_q      <= bcnt_d;
            conflict_q  <= conflict_d;
            idle_q      <= idle_d;
            hold_q      <= hold_d;
            hold_lit_q  <= (hold_d != '0);
            bit_valid_q <= bit_valid_d;
            bit_val_q   <= bit_val_d;
            match_q     <= match_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign bit_valid = bit_valid_q;
    assign bit_val   = bit_val_q;
    assign match     = match_q;
    assign match_cnt = match_cnt_q;

    // LED map: history low, bit count [11:8], conflict [14], match hold [15].
    always_comb begin
        led                    = '0;
        led[PATTERN_LEN-1:0]   = hist_q;
        led[11:8]              = bcnt_q;
        led[14]                = conflict_q;
        led[15]                = hold_lit_q;
    end

endmodule
